// File: rtl/mem_responder.sv
// Memory responder: target end of the CPU memory command interface.
// One outstanding read/write, fixed wait latency, single-cycle ready pulse, preload port.
module mem_responder #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mem_cmd,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              busy,
    output logic              cmd_err,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam logic [1:0] CMD_RSVD  = 2'b11;
    localparam logic [3:0] LAT_INIT  = 4'(LATENCY);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              is_write_q, is_write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;

    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_waddr_s;
    logic [DATA_W-1:0] mem_wdata_s;

    // Next-state, next-output and memory write-port selection.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_write_d  = is_write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        ready_d     = 1'b0;
        busy_d      = busy_q;
        err_d       = 1'b0;
        mem_we_s    = 1'b0;
        mem_waddr_s = addr_q;
        mem_wdata_s = wdata_q;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (load_en) begin
                    // Preload wins over any command presented in the same cycle.
                    mem_we_s    = 1'b1;
                    mem_waddr_s = load_addr;
                    mem_wdata_s = load_data;
                end else if ((mem_cmd == CMD_READ) || (mem_cmd == CMD_WRITE)) begin
                    is_write_d = (mem_cmd == CMD_WRITE);
                    addr_d     = mem_addr;
                    wdata_d    = mem_wdata;
                    busy_d     = 1'b1;
                    if (LAT_INIT == 4'd0) begin
                        state_d = ST_RESP;
                        cnt_d   = 4'd0;
                        ready_d = 1'b1;
                        if (mem_cmd == CMD_READ) begin
                            rdata_d = mem_q[mem_addr];
                        end else begin
                            rdata_d = rdata_q;
                        end
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = LAT_INIT;
                    end
                end else if (mem_cmd == CMD_RSVD) begin
                    err_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                busy_d = 1'b1;
                if (cnt_q <= 4'd1) begin
                    // Read data is fetched here so it appears together with mem_ready.
                    state_d = ST_RESP;
                    cnt_d   = 4'd0;
                    ready_d = 1'b1;
                    if (!is_write_q) begin
                        rdata_d = mem_q[addr_q];
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
                if (is_write_q) begin
                    mem_we_s = 1'b1;
                end else begin
                    mem_we_s = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Control state and registered outputs; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            is_write_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_write_q <= is_write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    // Storage array; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[mem_waddr_s] <= mem_wdata_s;
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_ready = ready_q;
    assign busy      = busy_q;
    assign cmd_err   = err_q;

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory responder for the simple RISC datapath: the target end of the CPU's memory command interface. It accepts one read or write command at a time, waits a configurable number of cycles, then completes the access with a one-cycle ready pulse. A preload port lets the bench or boot logic fill instruction and data words before the CPU is released from reset.

## Interface
- ADDR_W, 8: address width; memory depth is 2^ADDR_W words.
- DATA_W, 16: word width.
- LATENCY, 2: number of wait cycles between command acceptance and response; legal range 0–15.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- mem_cmd  in  2  command: 2'b00 NONE, 2'b01 READ, 2'b10 WRITE, 2'b11 reserved
- mem_addr  in  ADDR_W  word address, sampled at acceptance
- mem_wdata  in  DATA_W  write data, sampled at acceptance
- mem_rdata  out  DATA_W  registered read data
- mem_ready  out  1  one-cycle completion pulse
- busy  out  1  high from acceptance through the response cycle
- cmd_err  out  1  one-cycle pulse when a reserved command is seen in IDLE
- load_en  in  1  preload write strobe
- load_addr  in  ADDR_W  preload address
- load_data  in  DATA_W  preload data

One clock, `clk`. Reset `rst_n` is asynchronous and active-low.

## Operation
- Storage: 2^ADDR_W × DATA_W array. Contents are not cleared by reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If load_en is high, write load_data to load_addr. Any mem_cmd is not accepted that cycle, so load has priority.
  - Otherwise, on READ or WRITE: capture cmd, addr and wdata; load the wait counter with LATENCY; go to WAIT. If LATENCY=0, go directly to RESP.
  - On reserved command 2'b11: pulse cmd_err for one cycle, stay in IDLE, no access.
  - On NONE: stay in IDLE.
- WAIT:
  - Decrement the counter each cycle. When the counter reaches 0, go to RESP.
  - mem_cmd, mem_addr, mem_wdata and load_en are ignored.
- RESP:
  - Assert mem_ready for exactly one cycle.
  - READ: mem_rdata is updated to mem[captured addr] in the same cycle mem_ready is high.
  - WRITE: mem[captured addr] is updated at the end of the RESP cycle; mem_rdata is unchanged.
  - Always return to IDLE.
- mem_rdata holds its last read value until the next read response.
- Initiator rule: hold mem_cmd/addr/wdata until mem_ready is sampled high. Any non-NONE command present in IDLE is treated as a new request, including one held over from the previous access.
- Read-after-write to the same address returns the written data. The write commits before the next acceptance can occur.

## Timing
- Reset values: mem_rdata=0, mem_ready=0, busy=0, cmd_err=0, state=IDLE, counter=0.
- Reset asserted mid-operation aborts the access immediately. A pending write is dropped and the memory is not modified.
- Command accepted at edge N:
  - busy is high for cycles N+1 … N+LATENCY+1.
  - mem_ready is high only in cycle N+LATENCY+1.
- LATENCY=0: mem_ready is high in the cycle after acceptance.
- Minimum spacing between acceptances is LATENCY+2 cycles, because IDLE is always visited between requests.
- cmd_err is high in the cycle after the reserved command is sampled.
- Preload write is visible to a READ accepted on the following edge.

## Test plan
- Reset, then preload addr 0x05 with 16'h1234 and READ 0x05 with LATENCY=2 -> mem_ready high exactly 3 cycles after acceptance, mem_rdata=16'h1234, busy high for 3 cycles.
- WRITE 0x10 with 16'hBEEF, then READ 0x10 -> second response returns 16'hBEEF; mem_rdata is unchanged (still the prior value) during the write response.
- LATENCY=0 build: READ 0x00 after preloading 16'h0045 (69) -> mem_ready in the cycle after acceptance with rdata=69; back-to-back READs accepted every 2 cycles.
- mem_cmd=2'b11 in IDLE -> cmd_err pulses once, no mem_ready, busy stays 0. A READ asserted during WAIT is ignored, then accepted in IDLE after the response.
- load_en and READ 0x07 in the same IDLE cycle -> load commits and READ is not accepted; the held READ is accepted next cycle and returns the loaded value.
- WRITE 0x20 with 16'h00AA, rst_n dropped during WAIT -> all outputs return to 0 asynchronously; a later READ 0x20 returns the old contents, not 16'h00AA.
